// File: rtl/questao4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// questao4_rr_arbiter
//
// Round-robin arbiter that shares a 3-input select mux (sources B1/B2/B3)
// among three requesters. Request lines are level-sensitive: a source holds
// its req bit high for as long as it wants to own the mux. The arbiter drives
// the mux select code and a one-hot grant back to the requesters. All outputs
// are registered, so sel, gnt and busy always change together on one edge.
//
// Compile-time option:
//   ARB_HOLD_LIMIT_EN  when defined, a hold counter bounds ownership. An owner
//                      that keeps requesting while another source waits is
//                      rotated out after exactly MAX_HOLD owned cycles. When
//                      undefined, there is no counter. The owner keeps the mux
//                      until its req drops, and MAX_HOLD is ignored.
//
// Parameters:
//   MAX_HOLD  maximum consecutive owned cycles under contention (2..255)
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   3  request lines: bit0 = B1, bit1 = B2, bit2 = B3
//   sel    out  2  mux select code: 00 none, 01 B1, 10 B2, 11 B3
//   gnt    out  3  one-hot grant matching sel (000 when sel = 00)
//   busy   out  1  high while any source owns the mux
// ----------------------------------------------------------------------------
module questao4_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   output logic [1:0] sel,
   output logic [2:0] gnt,
   output logic       busy
);

   // Reject illegal configurations at elaboration time.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("questao4_rr_arbiter: MAX_HOLD must be within 2..255");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

   state_e     state_q, state_d;
   // In ST_OWN, last_q is the current owner. In ST_IDLE, it is the most recent owner.
   logic [1:0] last_q, last_d;
   logic [1:0] sel_q, sel_d;
   logic [2:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       hold_expired;
`endif

   // Modulo-3 successor of a source index (0 -> 1 -> 2 -> 0).
   function automatic logic [1:0] rr_step(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Search order from from_idx: from+1, from+2, then from itself if
   // incl_from is set. Returns {found, winner_index}.
   function automatic logic [2:0] rr_pick(input logic [2:0] req_v,
                                          input logic [1:0] from_idx,
                                          input logic       incl_from);
      logic [1:0] c1;
      logic [1:0] c2;
      c1 = rr_step(from_idx);
      c2 = rr_step(c1);
      if (req_v[c1])                          return {1'b1, c1};
      else if (req_v[c2])                     return {1'b1, c2};
      else if (incl_from && req_v[from_idx])  return {1'b1, from_idx};
      else                                    return 3'b000;
   endfunction

   logic [2:0] pick_any;    // any requester, pointer order from last_q
   logic [2:0] pick_other;  // requesters other than last_q
   logic       owner_req;
   logic       take_grant;
   logic       go_idle;
   logic [1:0] winner;

   assign pick_any   = rr_pick(req, last_q, 1'b1);
   assign pick_other = rr_pick(req, last_q, 1'b0);
   assign owner_req  = req[last_q];
`ifdef ARB_HOLD_LIMIT_EN
   assign hold_expired = (cnt_q == HOLD_TOP);
`endif

   // NOTE: every signal assigned in this block gets a default first so that no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      sel_d      = sel_q;
      gnt_d      = gnt_q;
      busy_d     = busy_q;
      take_grant = 1'b0;
      go_idle    = 1'b0;
      winner     = last_q;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_d      = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (pick_any[2]) begin
               take_grant = 1'b1;
               winner     = pick_any[1:0];
            end
         end
         ST_OWN: begin
            if (!owner_req) begin
               // Release. Hand over on the same edge if anyone else waits.
               if (pick_other[2]) begin
                  take_grant = 1'b1;
                  winner     = pick_other[1:0];
               end else begin
                  go_idle = 1'b1;
               end
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (hold_expired && pick_other[2]) begin
               // Forced rotation. The former owner re-competes later.
               take_grant = 1'b1;
               winner     = pick_other[1:0];
            end else if (!hold_expired) begin
               cnt_d = cnt_q + 8'd1;
            end
            // Expired with no contender: keep the owner and leave the counter saturated.
`endif
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (take_grant) begin
         state_d = ST_OWN;
         last_d  = winner;
         sel_d   = winner + 2'd1;
         gnt_d   = 3'b001 << winner;
         busy_d  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
         cnt_d   = 8'd0;
`endif
      end else if (go_idle) begin
         state_d = ST_IDLE;
         sel_d   = 2'b00;
         gnt_d   = 3'b000;
         busy_d  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 2'd2;      // first search order is B1, B2, B3
         sel_q   <= 2'b00;
         gnt_q   <= 3'b000;
         busy_q  <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
`ifdef ARB_HOLD_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign sel  = sel_q;
   assign gnt  = gnt_q;
   assign busy = busy_q;

endmodule
